// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_arb_pkg                                                 |
// | Description : Shared types and constants for the UART transmit arbiter:    |
// |               FSM state encoding, gap-counter width and a helper that      |
// |               turns the inter-byte delay into the counter's final value.   |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_arb_pkg;

   // Width of the gap / wait counter.
   localparam int unsigned C_GAP_CNT_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_SEND_LO = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_GAP_LO  = 3'd4,
      ST_SEND_HI = 3'd5,
      ST_WAIT_HI = 3'd6,
      ST_GAP_HI  = 3'd7
   } arb_state_e;

   // Counter value on the last cycle of a gap state. The counter starts at
   // zero on entry, so a delay of N ends at N-1. A delay of 0 still occupies
   // the gap state for one cycle, which is the same as a delay of 1.
   function automatic logic [C_GAP_CNT_W-1:0] gap_last(
      input logic [C_GAP_CNT_W-1:0] delay
   );
      if (delay == '0) begin
         return '0;
      end
      return delay - C_GAP_CNT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_picker                                                    |
// | Description : Combinational round-robin selector. Searches the request     |
// |               vector starting one past the last served index, wrapping     |
// |               modulo NUM_REQ, and returns the first active requester.      |
// | Ports       : req      [NUM_REQ-1:0] in  - request levels                  |
// |               last_idx [IDX_W-1:0]   in  - index served most recently      |
// |               valid                  out - at least one request is active  |
// |               winner   [IDX_W-1:0]   out - selected requester index        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_picker #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_idx,
   output logic               valid,
   output logic [IDX_W-1:0]   winner
);

   // Walk offsets 1..NUM_REQ from last_idx; the first hit wins. Offset
   // NUM_REQ brings the search back to last_idx itself, so a lone requester
   // that was served last time can be served again.
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand   = '0;
      valid  = 1'b0;
      winner = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((32'(last_idx) + off) % NUM_REQ);
         if (!valid && req[cand]) begin
            valid  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                              |
// | Description : Round-robin arbiter that lets NUM_REQ requesters share one   |
// |               UART byte transmitter. A winner's payload is captured, then  |
// |               one or two bytes are started on the UART, each followed by   |
// |               INTER_BYTE_DELAY idle cycles.                                |
// | Ports       : clk                         in  - rising-edge clock          |
// |               rst_n                       in  - async active-low reset     |
// |               req     [NUM_REQ-1:0]       in  - request levels             |
// |               send16  [NUM_REQ-1:0]       in  - 1: two bytes, 0: low byte  |
// |               data_in [NUM_REQ-1:0][15:0] in  - per-requester payload      |
// |               ack     [NUM_REQ-1:0]       out - one-hot capture pulse      |
// |               tx_data [7:0]               out - byte for the UART driver   |
// |               tx_start                    out - one-cycle byte start       |
// |               tx_busy                     in  - UART driver transmitting   |
// |               busy                        out - transaction in progress    |
// |               grant_id [IDX_W-1:0]        out - current/last served index  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ          = 4,
   parameter  int unsigned INTER_BYTE_DELAY = 1000000,
   localparam int unsigned IDX_W            = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       send16,
   input  logic [NUM_REQ-1:0][15:0] data_in,
   output logic [NUM_REQ-1:0]       ack,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   input  logic                     tx_busy,
   output logic                     busy,
   output logic [IDX_W-1:0]         grant_id
);

   localparam logic [C_GAP_CNT_W-1:0] C_GAP_LAST  = gap_last(INTER_BYTE_DELAY);
   // Resetting to the top index makes requester 0 the first candidate.
   localparam logic [IDX_W-1:0]       C_GRANT_RST = IDX_W'(NUM_REQ - 1);

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       win_q,   win_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [15:0]            data_q,  data_d;
   logic                   s16_q,   s16_d;
   logic [C_GAP_CNT_W-1:0] cnt_q,   cnt_d;

   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;
   logic                   wait_done;
   logic                   gap_done;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req      (req),
      .last_idx (grant_q),
      .valid    (pick_valid),
      .winner   (pick_idx)
   );

   // The first WAIT cycle ignores tx_busy: the driver may not have raised it
   // yet in response to tx_start. A non-zero counter marks that cycle as done.
   assign wait_done = (cnt_q != '0) && !tx_busy;
   assign gap_done  = (cnt_q == C_GAP_LAST);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      grant_d = grant_q;
      data_d  = data_q;
      s16_d   = s16_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               win_d   = pick_idx;
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            // Payload is frozen here; later changes to data_in/req are ignored.
            data_d  = data_in[win_q];
            s16_d   = send16[win_q];
            grant_d = win_q;
            state_d = ST_SEND_LO;
         end
         ST_SEND_LO: begin
            state_d = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (wait_done) begin
               state_d = ST_GAP_LO;
            end
         end
         ST_GAP_LO: begin
            if (gap_done) begin
               state_d = s16_q ? ST_SEND_HI : ST_IDLE;
            end
         end
         ST_SEND_HI: begin
            state_d = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (wait_done) begin
               state_d = ST_GAP_HI;
            end
         end
         ST_GAP_HI: begin
            if (gap_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Counter: cleared on every state change. In WAIT it only has to record
   // that the first cycle has passed, so it parks at 1 and cannot wrap back
   // to zero however long tx_busy stays high. In GAP it counts cycles.
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q) begin
         unique case (state_q)
            ST_WAIT_LO, ST_WAIT_HI: cnt_d = C_GAP_CNT_W'(1);
            ST_GAP_LO,  ST_GAP_HI:  cnt_d = cnt_q + C_GAP_CNT_W'(1);
            default:                cnt_d = '0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State and data registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         grant_q <= C_GRANT_RST;
         data_q  <= '0;
         s16_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         s16_q   <= s16_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs decode purely from registered state, so reset forces them to
   // their idle values without waiting for a clock edge.
   // ------------------------------------------------------------------------
   always_comb begin
      ack      = '0;
      tx_start = 1'b0;
      tx_data  = '0;
      unique case (state_q)
         ST_CAPTURE: begin
            ack[win_q] = 1'b1;
         end
         ST_SEND_LO: begin
            tx_start = 1'b1;
            tx_data  = data_q[7:0];
         end
         ST_WAIT_LO, ST_GAP_LO: begin
            tx_data = data_q[7:0];
         end
         ST_SEND_HI: begin
            tx_start = 1'b1;
            tx_data  = data_q[15:8];
         end
         ST_WAIT_HI, ST_GAP_HI: begin
            tx_data = data_q[15:8];
         end
         default: begin
            tx_data = '0;
         end
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                           |
// | Description : Scoreboard bench for uart_tx_arbiter. Stimulus pushes the    |
// |               expected ack / byte events; a monitor pops and compares      |
// |               each ack pulse and tx_start the DUT produces. A small UART   |
// |               model answers tx_start with a 3-cycle tx_busy.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

   localparam int NREQ     = 4;
   localparam int DELAY    = 4;
   localparam int UART_LEN = 3;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       send16;
   logic [NREQ-1:0][15:0] data_in;
   logic [NREQ-1:0]       ack;
   logic [7:0]            tx_data;
   logic                  tx_start;
   logic                  tx_busy;
   logic                  busy;
   logic [1:0]            grant_id;

   uart_tx_arbiter #(
      .NUM_REQ          (NREQ),
      .INTER_BYTE_DELAY (DELAY)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .send16   (send16),
      .data_in  (data_in),
      .ack      (ack),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .busy     (busy),
      .grant_id (grant_id)
   );

   typedef struct packed {
      logic       is_ack;
      logic [7:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   start_q[$];
   int   fall_q[$];
   int   cyc       = 0;
   int   errors    = 0;
   int   checks    = 0;
   int   idle_cyc  = 0;
   logic hold_busy = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
      end
   endtask

   task automatic expect_ack(input logic [3:0] m);
      exp_q.push_back('{is_ack: 1'b1, val: {4'b0000, m}});
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back('{is_ack: 1'b0, val: b});
   endtask

   task automatic sb_compare(input logic is_ack, input logic [7:0] val);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected: got %s 0x%0h, want no event",
                  is_ack ? "ack" : "byte", val);
      end else begin
         e = exp_q.pop_front();
         if (e.is_ack !== is_ack || e.val !== val) begin
            errors++;
            $display("FAIL sb_event: got %s 0x%0h, want %s 0x%0h",
                     is_ack ? "ack" : "byte", val, e.is_ack ? "ack" : "byte", e.val);
         end
      end
   endtask

   // Monitor: every ack pulse and tx_start is checked against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ack != '0) sb_compare(1'b1, {4'b0000, ack});
            if (tx_start) begin
               start_q.push_back(cyc);
               sb_compare(1'b0, tx_data);
            end
         end
      end
   end

   // UART driver model: busy for UART_LEN cycles after each tx_start.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (hold_busy) begin
            tx_busy = 1'b1;
         end else if (tx_start) begin
            tx_busy = 1'b1;
            repeat (UART_LEN) @(negedge clk);
            tx_busy = 1'b0;
            fall_q.push_back(cyc);
         end else begin
            tx_busy = 1'b0;
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      idle_cyc = cyc;
      check("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   // Raise the given request bits; drop each bit on its ack.
   task automatic serve(input logic [3:0] mask, input int budget);
      int n;
      n   = 0;
      req = req | mask;
      while (req != '0 && n < budget) begin
         @(negedge clk);
         n++;
         req = req & ~ack;
      end
      check("serve_acked", {28'd0, req}, 32'd0);
   endtask

   initial begin
      int nacks;
      int n;
      int bad;
      int f0;
      nacks   = 0;
      n       = 0;
      bad     = 0;
      f0      = 0;
      rst_n   = 1'b0;
      req     = '0;
      send16  = '0;
      data_in = '0;

      // ---- Reset values ----
      repeat (3) @(negedge clk);
      check("rst_ack",      {28'd0, ack},      32'd0);
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("rst_tx_data",  {24'd0, tx_data},  32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_grant",    {30'd0, grant_id}, 32'd3);
      rst_n = 1'b1;

      // ---- Single 8-bit request, latency and tail ----
      start_q.delete(); fall_q.delete();
      @(negedge clk);
      data_in[0] = 16'hA55A;
      send16     = 4'b0000;
      req        = 4'b0001;
      expect_ack(4'b0001);
      expect_byte(8'h5A);
      @(negedge clk);
      check("lat_ack", {28'd0, ack}, 32'h1);
      req = 4'b0000;
      @(negedge clk);
      check("lat_start", {31'd0, tx_start}, 32'd1);
      check("lat_data",  {24'd0, tx_data},  32'h5A);
      check("lat_busy",  {31'd0, busy},     32'd1);
      wait_idle(200);
      f0 = (fall_q.size() > 0) ? fall_q[0] : -1000;
      // one cycle for WAIT to see tx_busy low, then 4 gap cycles
      check("tail8_cycles", 32'(idle_cyc - f0), 32'd5);
      check("idle_tx_data", {24'd0, tx_data},  32'd0);
      check("grant_after0", {30'd0, grant_id}, 32'd0);

      // ---- 16-bit request ----
      start_q.delete(); fall_q.delete();
      data_in[2] = 16'h1234;
      send16     = 4'b0100;
      expect_ack(4'b0100);
      expect_byte(8'h34);
      expect_byte(8'h12);
      serve(4'b0100, 50);
      wait_idle(300);
      check("hi_starts", 32'(start_q.size()), 32'd2);
      f0 = (fall_q.size() > 0) ? fall_q[0] : -1000;
      check("hi_gap_cycles", 32'((start_q.size() > 1 ? start_q[1] : 0) - f0), 32'd5);
      check("grant_after2", {30'd0, grant_id}, 32'd2);

      // ---- Contention after a fresh reset: order 0,1,2,3,0 ----
      rst_n = 1'b0;
      @(negedge clk);
      check("rst2_grant", {30'd0, grant_id}, 32'd3);
      rst_n  = 1'b1;
      send16 = 4'b0000;
      for (int i = 0; i < NREQ; i++) data_in[i] = 16'h00A0 + 16'(i);
      expect_ack(4'b0001); expect_byte(8'hA0);
      expect_ack(4'b0010); expect_byte(8'hA1);
      expect_ack(4'b0100); expect_byte(8'hA2);
      expect_ack(4'b1000); expect_byte(8'hA3);
      expect_ack(4'b0001); expect_byte(8'hA0);
      req   = 4'b1111;
      nacks = 0;
      n     = 0;
      while (nacks < 5 && n < 400) begin
         @(negedge clk);
         n++;
         if (ack != '0) begin
            nacks++;
            if (nacks == 5) req = 4'b0000;
         end
      end
      check("contend_acks", 32'(nacks), 32'd5);
      wait_idle(200);
      check("contend_grant", {30'd0, grant_id}, 32'd0);

      // ---- Wrap: get grant to 3, then req=1001 -> 0 then 3 ----
      data_in[3] = 16'h0033;
      data_in[0] = 16'h0011;
      expect_ack(4'b1000); expect_byte(8'h33);
      serve(4'b1000, 50);
      wait_idle(200);
      check("wrap_grant3", {30'd0, grant_id}, 32'd3);
      expect_ack(4'b0001); expect_byte(8'h11);
      expect_ack(4'b1000); expect_byte(8'h33);
      serve(4'b1001, 200);
      wait_idle(200);
      check("wrap_last", {30'd0, grant_id}, 32'd3);

      // ---- Reset during WAIT_HI with 0 and 2 pending ----
      data_in[1] = 16'hBEEF;
      send16     = 4'b0010;
      expect_ack(4'b0010); expect_byte(8'hEF); expect_byte(8'hBE);
      serve(4'b0010, 50);
      n     = 0;
      nacks = 0;
      while (nacks < 2 && n < 200) begin
         @(negedge clk);
         n++;
         if (tx_start) nacks++;
      end
      check("mid_starts", 32'(nacks), 32'd2);
      data_in[0] = 16'h00C3;
      data_in[2] = 16'h0077;
      send16     = 4'b0000;
      req        = 4'b0101;
      @(negedge clk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ack",      {28'd0, ack},      32'd0);
      check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("mid_rst_tx_data",  {24'd0, tx_data},  32'd0);
      check("mid_rst_busy",     {31'd0, busy},     32'd0);
      check("mid_rst_grant",    {30'd0, grant_id}, 32'd3);
      expect_ack(4'b0001); expect_byte(8'hC3);
      expect_ack(4'b0100); expect_byte(8'h77);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ack", {28'd0, ack}, 32'h1);
      req = req & ~ack;
      serve(4'b0000, 200);
      wait_idle(200);
      check("post_rst_grant", {30'd0, grant_id}, 32'd2);

      // ---- Stuck UART ----
      start_q.delete(); fall_q.delete();
      hold_busy  = 1'b1;
      data_in[1] = 16'h6699;
      send16     = 4'b0010;
      expect_ack(4'b0010); expect_byte(8'h99);
      serve(4'b0010, 50);
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (!busy) bad++;
      end
      check("stuck_busy_lost", 32'(bad), 32'd0);
      check("stuck_starts", 32'(start_q.size()), 32'd1);
      expect_byte(8'h66);
      hold_busy = 1'b0;
      wait_idle(300);
      check("stuck_release_starts", 32'(start_q.size()), 32'd2);

      repeat (5) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
